// File: rtl/comparator_self_test.sv
// Exhaustive self-test controller for a WIDTH-bit magnitude comparator: sweeps every (A,B) pair,
// holds each SETTLE+1 cycles, checks the CUT against a golden compare and logs mismatches.
module comparator_self_test #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   A_out,
  output logic [WIDTH-1:0]   B_out,
  input  logic               A_greater_B,
  input  logic               A_equal_B,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   first_fail_A,
  output logic [WIDTH-1:0]   first_fail_B
);

  localparam int          EW       = 2 * WIDTH + 1;
  localparam logic [3:0]  SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_busy, r_done, r_pass, r_fail_valid;
  logic [EW-1:0]    r_err_count;
  logic [WIDTH-1:0] r_ff_a, r_ff_b;

  logic             w_exp_gt, w_exp_eq, w_mismatch, w_sample, w_last;
  logic [EW-1:0]    w_err_next;

  assign w_exp_gt   = (r_a > r_b);
  assign w_exp_eq   = (r_a == r_b);
  assign w_mismatch = (A_greater_B != w_exp_gt) || (A_equal_B != w_exp_eq);
  assign w_sample   = (r_cnt == SETTLE_C);
  assign w_last     = &{r_a, r_b};
  assign w_err_next = r_err_count + EW'(w_mismatch);

  // NOTE: all state here is sequential, so every assignment uses <= to avoid ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_ff_a       <= '0;
      r_ff_b       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_APPLY;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_ff_a       <= '0;
            r_ff_b       <= '0;
          end
        end
        S_APPLY: begin
          if (w_sample) begin
            r_cnt       <= '0;
            r_err_count <= w_err_next;
            if (w_mismatch && !r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_ff_a       <= r_a;
              r_ff_b       <= r_b;
            end
            if (w_last) begin
              // Operands stay at all-ones once the sweep completes.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              {r_a, r_b} <= {r_a, r_b} + (2 * WIDTH)'(1);
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A_out        = r_a;
  assign B_out        = r_b;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign err_count    = r_err_count;
  assign fail_valid   = r_fail_valid;
  assign first_fail_A = r_ff_a;
  assign first_fail_B = r_ff_b;

endmodule

// File: tb/tb_comparator_self_test.sv
// Directed bench: default controller with selectable faulty CUTs, plus SETTLE=0/1 controllers
// driving a CUT whose outputs lag by one register.
module tb_comparator_self_test;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cut_mode = 0;  // 0 golden, 1 eq stuck at 0, 2 gt computed as A<B

  // Default controller (SETTLE=2)
  logic [2:0] a_out, b_out, ff_a, ff_b;
  logic       gt, eq, busy, done, pass, fail_valid;
  logic [6:0] err_count;

  always_comb begin
    gt = (a_out > b_out);
    eq = (a_out == b_out);
    if (cut_mode == 1) eq = 1'b0;
    if (cut_mode == 2) gt = (a_out < b_out);
  end

  comparator_self_test #(.WIDTH(3), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .A_out(a_out), .B_out(b_out),
    .A_greater_B(gt), .A_equal_B(eq), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .first_fail_A(ff_a), .first_fail_B(ff_b));

  // SETTLE=0 and SETTLE=1 controllers, each with a one-cycle-late CUT
  logic [2:0] a0, b0, ffa0, ffb0, a1, b1, ffa1, ffb1;
  logic       gt0, eq0, busy0, done0, pass0, fv0;
  logic       gt1, eq1, busy1, done1, pass1, fv1;
  logic [6:0] err0, err1;

  always @(posedge clk) begin
    gt0 <= (a0 > b0);
    eq0 <= (a0 == b0);
    gt1 <= (a1 > b1);
    eq1 <= (a1 == b1);
  end

  comparator_self_test #(.WIDTH(3), .SETTLE(0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start), .A_out(a0), .B_out(b0),
    .A_greater_B(gt0), .A_equal_B(eq0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .first_fail_A(ffa0), .first_fail_B(ffb0));

  comparator_self_test #(.WIDTH(3), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start), .A_out(a1), .B_out(b1),
    .A_greater_B(gt1), .A_equal_B(eq1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .first_fail_A(ffa1), .first_fail_B(ffb1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse (or hold) start so edge k samples it; return edges from k until done is seen.
  task automatic run(input bit hold, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check("busy_at_start", {31'd0, busy}, 32'd1);
    check("done_at_start", {31'd0, done}, 32'd0);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      cycles = 1;
    end else begin
      cycles = 0;
    end
    while (!done && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int cyc;

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {25'd0, err_count}, 32'd0);
    check("rst_a", {29'd0, a_out}, 32'd0);
    rst = 1'b0;

    // 1: golden CUT; also run 6 with the lagging CUTs in parallel
    cut_mode = 0;
    run(1'b0, cyc);
    check("t1_cycles", cyc, 32'd192);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_err", {25'd0, err_count}, 32'd0);
    check("t1_fv", {31'd0, fail_valid}, 32'd0);
    check("t1_a", {29'd0, a_out}, 32'd7);
    check("t1_b", {29'd0, b_out}, 32'd7);
    check("t1_busy", {31'd0, busy}, 32'd0);
    // 6: SETTLE=0 sees the previous vector's result; SETTLE=1 tolerates the lag
    check("t6_s0_done", {31'd0, done0}, 32'd1);
    check("t6_s0_err", {25'd0, err0}, 32'd21);
    check("t6_s0_pass", {31'd0, pass0}, 32'd0);
    check("t6_s0_ff", {26'd0, ffa0, ffb0}, 32'd1);
    check("t6_s1_done", {31'd0, done1}, 32'd1);
    check("t6_s1_pass", {31'd0, pass1}, 32'd1);
    check("t6_s1_err", {25'd0, err1}, 32'd0);

    // 2: A_equal_B stuck at 0
    cut_mode = 1;
    run(1'b0, cyc);
    check("t2_cycles", cyc, 32'd192);
    check("t2_err", {25'd0, err_count}, 32'd8);
    check("t2_pass", {31'd0, pass}, 32'd0);
    check("t2_fv", {31'd0, fail_valid}, 32'd1);
    check("t2_ff", {26'd0, ff_a, ff_b}, 32'd0);

    // 3: A_greater_B computed as A<B
    cut_mode = 2;
    run(1'b0, cyc);
    check("t3_err", {25'd0, err_count}, 32'd56);
    check("t3_pass", {31'd0, pass}, 32'd0);
    check("t3_ff", {26'd0, ff_a, ff_b}, 32'd1);

    // 4: async reset mid-run, then a full run
    cut_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("t4_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_err", {25'd0, err_count}, 32'd0);
    check("t4_ab", {26'd0, a_out, b_out}, 32'd0);
    check("t4_fv", {31'd0, fail_valid}, 32'd0);
    check("t4_ff", {26'd0, ff_a, ff_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cut_mode = 0;
    run(1'b0, cyc);
    check("t4_cycles", cyc, 32'd192);
    check("t4_pass", {31'd0, pass}, 32'd1);

    // 5: start held high through APPLY, restart from DONE clears counters
    cut_mode = 1;
    run(1'b1, cyc);
    check("t5_cycles", cyc, 32'd192);
    check("t5_err", {25'd0, err_count}, 32'd8);
    @(posedge clk); #1;
    check("t5_restart_busy", {31'd0, busy}, 32'd1);
    check("t5_restart_done", {31'd0, done}, 32'd0);
    check("t5_restart_err", {25'd0, err_count}, 32'd0);
    check("t5_restart_fv", {31'd0, fail_valid}, 32'd0);
    check("t5_restart_ab", {26'd0, a_out, b_out}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
